// File: rtl/qerv_mdu.sv
// qerv_mdu -- iterative RV32M multiply/divide unit for the qerv extension port.
//
// A request is accepted in IDLE when i_mdu_valid is high. Operand magnitudes
// are latched, 32 shift-add (multiply) or restoring (divide) steps run in BUSY,
// and the sign-corrected result is presented in DONE with a one-cycle
// o_mdu_ready pulse. Every op takes exactly 33 cycles from the start cycle.
//
// Ports:
//   clk          clock, rising edge
//   i_rst        synchronous active-high reset
//   i_mdu_valid  request valid (core o_mdu_valid)
//   i_mdu_rs1    operand A (core o_ext_rs1)
//   i_mdu_rs2    operand B (core o_ext_rs2)
//   i_mdu_op     funct3: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   o_mdu_rd     result word, held until the next completion (core i_ext_rd)
//   o_mdu_ready  one-cycle result-valid pulse (core i_ext_ready)
`timescale 1ns/1ps

module qerv_mdu (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_mdu_valid,
    input  logic [31:0] i_mdu_rs1,
    input  logic [31:0] i_mdu_rs2,
    input  logic [2:0]  i_mdu_op,
    output logic [31:0] o_mdu_rd,
    output logic        o_mdu_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [2:0]  r_op;
    logic [63:0] r_acc;      // multiply: {partial high, multiplier}; divide: {remainder, quotient}
    logic [31:0] r_b;        // multiplicand magnitude or divisor magnitude
    logic        r_neg_q;    // negate product / quotient at the end
    logic        r_neg_r;    // negate remainder at the end
    logic        r_dz;       // divisor was zero
    logic [4:0]  r_cnt;

    // Operand decode at the start cycle
    logic        w_rs1_signed;
    logic        w_rs2_signed;
    logic        w_neg1;
    logic        w_neg2;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;

    assign w_rs1_signed = (i_mdu_op == 3'b001) || (i_mdu_op == 3'b010) ||
                          (i_mdu_op == 3'b100) || (i_mdu_op == 3'b110);
    assign w_rs2_signed = (i_mdu_op == 3'b001) || (i_mdu_op == 3'b100) ||
                          (i_mdu_op == 3'b110);
    assign w_neg1 = w_rs1_signed & i_mdu_rs1[31];
    assign w_neg2 = w_rs2_signed & i_mdu_rs2[31];
    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign w_mag1 = w_neg1 ? (32'd0 - i_mdu_rs1) : i_mdu_rs1;
    assign w_mag2 = w_neg2 ? (32'd0 - i_mdu_rs2) : i_mdu_rs2;

    // One iteration step
    logic [32:0] w_sum;       // multiply partial add
    logic [32:0] w_rem_sh;    // remainder shifted left with next dividend bit
    logic [32:0] w_diff;      // trial subtraction
    logic [63:0] w_acc_next;

    assign w_sum    = {1'b0, r_acc[63:32]} + {1'b0, r_b};
    assign w_rem_sh = r_acc[63:31];
    // The shifted remainder is below twice the divisor, so the 33-bit
    // difference always fits and bit 32 is its sign.
    assign w_diff   = w_rem_sh - {1'b0, r_b};

    always_comb begin
        w_acc_next = r_acc;
        if (r_op[2]) begin
            if (!w_diff[32]) begin
                w_acc_next = {w_diff[31:0], r_acc[30:0], 1'b1};
            end else begin
                w_acc_next = {r_acc[62:0], 1'b0};
            end
        end else begin
            if (r_acc[0]) begin
                w_acc_next = {w_sum, r_acc[31:1]};
            end else begin
                w_acc_next = {1'b0, r_acc[63:1]};
            end
        end
    end

    // Result selection with sign correction, taken from the final step's
    // accumulator so the result is registered on entry to DONE.
    logic [63:0] w_prod_fix;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_result;

    assign w_prod_fix = r_neg_q ? (64'd0 - w_acc_next) : w_acc_next;
    assign w_quot_fix = r_neg_q ? (32'd0 - w_acc_next[31:0]) : w_acc_next[31:0];
    assign w_rem_fix  = r_neg_r ? (32'd0 - w_acc_next[63:32]) : w_acc_next[63:32];

    always_comb begin
        w_result = 32'd0;
        case (r_op)
            3'b000:                 w_result = w_prod_fix[31:0];
            3'b001, 3'b010, 3'b011: w_result = w_prod_fix[63:32];
            // Divide by zero yields an all-ones quotient magnitude; its
            // negation is suppressed so both DIV and DIVU return 0xFFFFFFFF.
            3'b100, 3'b101:         w_result = r_dz ? 32'hFFFF_FFFF : w_quot_fix;
            default:                w_result = w_rem_fix;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_mdu_valid) w_state_next = S_BUSY;
            S_BUSY:  if (r_cnt == 5'd31) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_op        <= 3'd0;
            r_acc       <= 64'd0;
            r_b         <= 32'd0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dz        <= 1'b0;
            r_cnt       <= 5'd0;
            o_mdu_rd    <= 32'd0;
            o_mdu_ready <= 1'b0;
        end else begin
            o_mdu_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_mdu_valid) begin
                        r_op    <= i_mdu_op;
                        r_acc   <= {32'd0, w_mag1};
                        r_b     <= w_mag2;
                        r_neg_q <= w_neg1 ^ w_neg2;
                        r_neg_r <= w_neg1;
                        r_dz    <= (i_mdu_rs2 == 32'd0);
                        r_cnt   <= 5'd0;
                    end
                end
                S_BUSY: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        o_mdu_rd    <= w_result;
                        o_mdu_ready <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/qerv_mdu.md
# qerv_mdu

Iterative RV32M multiply/divide unit that answers the core's extension port. It sits outside `qerv_top`, next to the register-file wrapper. It accepts a request qualified by the core's `o_mdu_valid`, with `o_ext_rs1`, `o_ext_rs2` and `o_ext_funct3`. After a fixed 33-cycle latency it returns a 32-bit result on `i_ext_rd` together with a single-cycle `i_ext_ready` pulse. Internally it runs a radix-2 shift-add multiplier and a restoring divider on operand magnitudes, shared over one 32-step counter, with sign correction at the end.

## Interface
- No parameters.
- `clk` in 1: clock; all state updates on the rising edge.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_mdu_valid` in 1: request valid; connects to core `o_mdu_valid`.
- `i_mdu_rs1` in 32: operand A; connects to `o_ext_rs1`.
- `i_mdu_rs2` in 32: operand B; connects to `o_ext_rs2`.
- `i_mdu_op` in 3: operation select; connects to `o_ext_funct3`.
- `o_mdu_rd` out 32: result; connects to `i_ext_rd`.
- `o_mdu_ready` out 1: result-valid pulse; connects to `i_ext_ready`.

## Operation
- `i_mdu_op` encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- Operand signedness:
  - rs1 is signed for MULH, MULHSU, DIV and REM.
  - rs2 is signed for MULH, DIV and REM.
  - All other operand/op combinations are unsigned.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - When `i_mdu_valid`=1, latch the op, the operand magnitudes, the result sign, and a divisor-zero flag.
  - Clear the 5-bit step counter and go to BUSY.
  - When `i_mdu_valid`=0, stay in IDLE.
- BUSY: perform one iteration per cycle.
  - Multiply: if multiplier LSB=1, add the multiplicand into the upper half of the 64-bit accumulator, then shift right 1 (33-bit add).
  - Divide: shift the remainder:quotient pair left 1, trial-subtract the divisor (33-bit), and keep the difference if it is non-negative.
  - After the step where counter=31, go to DONE.
- DONE:
  - Apply the sign correction (two's complement) and select the result word.
  - Register it into `o_mdu_rd`, assert `o_mdu_ready` for this one cycle, then return to IDLE.
- Result selection:
  - MUL returns product[31:0].
  - MULH, MULHSU and MULHU return product[63:32].
  - DIV and DIVU return the quotient.
  - REM and REMU return the remainder.
- Signs:
  - Product sign = sign(rs1) XOR sign(rs2), using signed operands only.
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(rs1).
- Divide by zero:
  - DIV and DIVU return 0xFFFFFFFF; quotient negation is suppressed.
  - REM and REMU return rs1 unchanged.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000, REM returns 0.
- `i_mdu_valid` is ignored in BUSY and DONE. Operands are sampled only in the IDLE start cycle; later input changes have no effect.
- Handshake contract: the core holds valid until it sees ready, then drops valid in the next cycle. If valid is still high in IDLE, a new operation starts; this is legal and is not an error.

## Timing
- Start is sampled at the edge ending cycle 0 (IDLE with valid=1).
- BUSY occupies cycles 1–32. DONE is cycle 33: `o_mdu_ready`=1 and `o_mdu_rd` is valid.
- Fixed latency of 33 cycles for every op; there is no early termination.
- Minimum start-to-start spacing is 34 cycles (next start at cycle 34).
- `o_mdu_ready` is registered and high for exactly one cycle per start.
- `o_mdu_rd` holds its value until the next DONE.
- Reset values: state=IDLE, counter=0, `o_mdu_ready`=0, `o_mdu_rd`=0. Datapath registers are also cleared.
- Reset asserted in any state, including mid-BUSY or in DONE: the next cycle is IDLE and no ready pulse is produced for the aborted operation.
- Reset and valid in the same cycle: reset wins and no operation starts.

## Test plan
- MUL 7 × 6: ready exactly 33 cycles after the start cycle; rd = 0x0000002A; ready is high for 1 cycle only.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → rd = 0x00000000. MULHU with the same operands → rd = 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → rd = 0xFFFFFFFF.
- DIV −7 / 2 → rd = 0xFFFFFFFD. REM −7 / 2 → rd = 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- Divide by zero with rs1=0x80000005: DIV → 0xFFFFFFFF, DIVU → 0xFFFFFFFF, REM → 0x80000005, REMU → 0x80000005.
- Overflow 0x80000000 / 0xFFFFFFFF: DIV → 0x80000000, REM → 0x00000000.
- Robustness:
  - Change operands and op during BUSY: the result matches the originally latched values.
  - Pulse `i_rst` at cycle 15 of BUSY: no ready pulse and `o_mdu_rd`=0; a new MUL 3 × 5 started afterwards returns 15 after 33 cycles.
  - Valid held continuously: a back-to-back start occurs at cycle 34.
